// File: rtl/ppu_pixel_writer_pkg.sv
// ppu_pixel_writer_pkg: shared state encoding, greyscale mask and palette mirroring helper
package ppu_pixel_writer_pkg;
  typedef enum logic [1:0] {IDLE, LOOKUP, EMIT} state_t;
  localparam logic [15:0] GREY_MASK = 16'hFFF0;
  // Backdrop mirrors: 0x10/14/18/1C fold onto 0x00/04/08/0C.
  function automatic logic [15:0] pal_mirror(input logic [15:0] a);
    return (a[1:0] == 2'b00) ? {a[15:5], 1'b0, a[3:0]} : a;
  endfunction
endpackage

// File: rtl/ppu_pixel_writer_if.sv
// ppu_pixel_writer_if: framebuffer write bus
// color_addr: write address, color_data: {emphasis, colour}, color_wren: write strobe
interface ppu_pixel_writer_if #(
  parameter int FB_ADDR_W = 16,
  parameter int COLOR_W = 6
);
  logic [FB_ADDR_W-1:0] color_addr;
  logic [COLOR_W+2:0] color_data;
  logic color_wren;
  modport master (output color_addr, color_data, color_wren);
  modport slave (input color_addr, color_data, color_wren);
endinterface

// File: rtl/ppu_pixel_writer_palette_ram.sv
// ppu_pixel_writer_palette_ram: palette RAM, mirrored CPU write/read port plus render lookup port
// pal_addr/pal_wdata/pal_wr: CPU write, pal_rdata: registered CPU read
// rd_index: renderer colour index, rd_color: combinational lookup (pre-write contents)
module ppu_pixel_writer_palette_ram
  import ppu_pixel_writer_pkg::*;
#(
  parameter int PAL_ENTRIES = 32,
  parameter int COLOR_W = 6,
  localparam int PAL_AW = $clog2(PAL_ENTRIES)
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic [PAL_AW-1:0]  pal_addr,
  input  logic [COLOR_W-1:0] pal_wdata,
  input  logic               pal_wr,
  output logic [COLOR_W-1:0] pal_rdata,
  input  logic [4:0]         rd_index,
  output logic [COLOR_W-1:0] rd_color
);
  logic [COLOR_W-1:0] mem [PAL_ENTRIES];
  logic [PAL_AW-1:0] cpu_a, rnd_a;
  logic [COLOR_W-1:0] rdata_d, rdata_q;
  always_comb begin
    cpu_a = PAL_AW'(pal_mirror(16'(pal_addr)));
    // Any index with [1:0]==0 shows the universal backdrop.
    rnd_a = (rd_index[1:0] == 2'b00) ? '0 : PAL_AW'(rd_index);
    rdata_d = mem[cpu_a];
  end
  always_ff @(posedge sysclk) if (pal_wr) mem[cpu_a] <= pal_wdata;
  always_ff @(posedge sysclk) rdata_q <= !reset ? '0 : rdata_d;
  assign pal_rdata = rdata_q;
  assign rd_color = mem[rnd_a];
endmodule

// File: rtl/ppu_pixel_writer.sv
// ppu_pixel_writer: palette lookup, greyscale/emphasis, upscaled N-buffered framebuffer writer
// Inputs: ppu_clock dot enable, pix_valid/pix_index pixel, greyscale/emphasis mask, v_blank level,
//         pal_* CPU palette port. Outputs: fb write bus, disp_frame, frame_done pulse, sticky overrun.
module ppu_pixel_writer
  import ppu_pixel_writer_pkg::*;
#(
  parameter int PAL_ENTRIES = 32,
  parameter int COLOR_W = 6,
  parameter int H_PIXELS = 256,
  parameter int V_LINES = 240,
  parameter int SCALE = 1,
  parameter int FRAMES = 1,
  parameter int FB_ADDR_W = 16,
  localparam int PAL_AW = $clog2(PAL_ENTRIES)
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic               ppu_clock,
  input  logic [PAL_AW-1:0]  pal_addr,
  input  logic [COLOR_W-1:0] pal_wdata,
  input  logic               pal_wr,
  output logic [COLOR_W-1:0] pal_rdata,
  input  logic               pix_valid,
  input  logic [4:0]         pix_index,
  input  logic               greyscale,
  input  logic [2:0]         emphasis,
  input  logic               v_blank,
  ppu_pixel_writer_if.master fb,
  output logic [1:0]         disp_frame,
  output logic               frame_done,
  output logic               overrun
);
  localparam int XW = $clog2(H_PIXELS);
  localparam int YW = $clog2(V_LINES + 1);
  localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] Y_END = YW'(V_LINES);
  localparam logic [1:0] SUB_LAST = 2'(SCALE * SCALE - 1);
  localparam logic [1:0] F_LAST = 2'(FRAMES - 1);
  localparam logic [FB_ADDR_W-1:0] LINE_SZ = FB_ADDR_W'(H_PIXELS * SCALE);
  localparam logic [FB_ADDR_W-1:0] FRAME_SZ = FB_ADDR_W'(H_PIXELS * V_LINES * SCALE * SCALE);
  localparam logic [FB_ADDR_W-1:0] SCALE_A = FB_ADDR_W'(SCALE);
  state_t state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [1:0] sub_q, sub_d, disp_q, disp_d, wr_frame_q, wr_frame_d;
  logic [FB_ADDR_W-1:0] base_q, base_d;
  logic [COLOR_W-1:0] col_q, col_d, rd_color;
  logic [2:0] emph_q, emph_d;
  logic [4:0] idx_q, idx_d;
  logic vb_q, vb_d, fdone_q, fdone_d, ovr_q, ovr_d, offer, accept, vb_edge;
  ppu_pixel_writer_palette_ram #(.PAL_ENTRIES(PAL_ENTRIES), .COLOR_W(COLOR_W)) u_pal (
    .sysclk, .reset, .pal_addr, .pal_wdata, .pal_wr, .pal_rdata,
    .rd_index(idx_q), .rd_color
  );
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    sub_d = sub_q;
    base_d = base_q;
    col_d = col_q;
    emph_d = emph_q;
    idx_d = idx_q;
    disp_d = disp_q;
    wr_frame_d = wr_frame_q;
    ovr_d = ovr_q;
    vb_d = v_blank;
    fdone_d = 1'b0;
    offer = ppu_clock & pix_valid;
    accept = offer && state_q == IDLE && y_q != Y_END;
    vb_edge = v_blank & ~vb_q;
    if (accept) begin
      state_d = LOOKUP;
      idx_d = pix_index;
      emph_d = emphasis;
      // Base of the SCALE x SCALE block is latched so a mid-burst frame swap cannot move it.
      base_d = FB_ADDR_W'(wr_frame_q) * FRAME_SZ + FB_ADDR_W'(y_q) * SCALE_A * LINE_SZ
             + FB_ADDR_W'(x_q) * SCALE_A;
      x_d = (x_q == X_LAST) ? '0 : x_q + XW'(1);
      y_d = (x_q == X_LAST) ? y_q + YW'(1) : y_q;
    end else if (offer) ovr_d = 1'b1;
    if (state_q == LOOKUP) begin
      state_d = EMIT;
      col_d = greyscale ? rd_color & COLOR_W'(GREY_MASK) : rd_color;
    end
    if (state_q == EMIT) begin
      state_d = (sub_q == SUB_LAST) ? IDLE : EMIT;
      sub_d = (sub_q == SUB_LAST) ? 2'd0 : sub_q + 2'd1;
    end
    if (vb_edge) begin
      fdone_d = 1'b1;
      disp_d = wr_frame_q;
      wr_frame_d = (wr_frame_q == F_LAST) ? 2'd0 : wr_frame_q + 2'd1;
      x_d = '0;
      y_d = '0;
      ovr_d = 1'b0;
    end
  end
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      sub_q <= '0;
      base_q <= '0;
      col_q <= '0;
      emph_q <= '0;
      idx_q <= '0;
      disp_q <= '0;
      wr_frame_q <= '0;
      ovr_q <= 1'b0;
      vb_q <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      sub_q <= sub_d;
      base_q <= base_d;
      col_q <= col_d;
      emph_q <= emph_d;
      idx_q <= idx_d;
      disp_q <= disp_d;
      wr_frame_q <= wr_frame_d;
      ovr_q <= ovr_d;
      vb_q <= vb_d;
      fdone_q <= fdone_d;
    end
  end
  // sub[0] is dx, sub[1] is dy.
  assign fb.color_addr = base_q + (sub_q[1] ? LINE_SZ : '0) + FB_ADDR_W'(sub_q[0]);
  assign fb.color_data = {emph_q, col_q};
  assign fb.color_wren = state_q == EMIT;
  assign disp_frame = disp_q;
  assign frame_done = fdone_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_ppu_pixel_writer.sv
// tb_ppu_pixel_writer: two writer instances (1x single-buffer, 2x double-buffer) against a reference model
module tb_ppu_pixel_writer;
  localparam int H = 16;
  localparam int V = 8;
  localparam int FW = 12;
  logic sysclk = 1'b0;
  logic reset = 1'b0;
  logic ppu_clock = 1'b0;
  logic [4:0] pal_addr = '0;
  logic [5:0] pal_wdata = '0;
  logic pal_wr = 1'b0;
  logic pix_valid = 1'b0;
  logic [4:0] pix_index = '0;
  logic greyscale = 1'b0;
  logic [2:0] emphasis = '0;
  logic v_blank = 1'b0;
  logic [5:0] rd1, rd2;
  logic [1:0] df1, df2;
  logic fd1, fd2, ov1, ov2;
  int n_tests = 0;
  int n_fail = 0;
  int pal_m[32];
  int mx = 0, my = 0;
  int fr[2] = '{0, 0};
  int disp[2] = '{0, 0};
  int sc[2] = '{1, 2};
  int nf[2] = '{1, 2};
  bit ovr = 0;
  ppu_pixel_writer_if #(.FB_ADDR_W(FW), .COLOR_W(6)) fb1 ();
  ppu_pixel_writer_if #(.FB_ADDR_W(FW), .COLOR_W(6)) fb2 ();
  ppu_pixel_writer #(.H_PIXELS(H), .V_LINES(V), .SCALE(1), .FRAMES(1), .FB_ADDR_W(FW)) u1 (
    .sysclk(sysclk), .reset(reset), .ppu_clock(ppu_clock), .pal_addr(pal_addr),
    .pal_wdata(pal_wdata), .pal_wr(pal_wr), .pal_rdata(rd1), .pix_valid(pix_valid),
    .pix_index(pix_index), .greyscale(greyscale), .emphasis(emphasis), .v_blank(v_blank),
    .fb(fb1), .disp_frame(df1), .frame_done(fd1), .overrun(ov1)
  );
  ppu_pixel_writer #(.H_PIXELS(H), .V_LINES(V), .SCALE(2), .FRAMES(2), .FB_ADDR_W(FW)) u2 (
    .sysclk(sysclk), .reset(reset), .ppu_clock(ppu_clock), .pal_addr(pal_addr),
    .pal_wdata(pal_wdata), .pal_wr(pal_wr), .pal_rdata(rd2), .pix_valid(pix_valid),
    .pix_index(pix_index), .greyscale(greyscale), .emphasis(emphasis), .v_blank(v_blank),
    .fb(fb2), .disp_frame(df2), .frame_done(fd2), .overrun(ov2)
  );
  always #5 sysclk = ~sysclk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic tick;
    @(posedge sysclk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int mir(input int a);
    if (a == 16 || a == 20 || a == 24 || a == 28) return a - 16;
    return a;
  endfunction
  task automatic pal_write(input int a, input int d);
    pal_addr = 5'(a);
    pal_wdata = 6'(d);
    pal_wr = 1'b1;
    tick;
    pal_wr = 1'b0;
    pal_m[mir(a)] = d;
  endtask
  task automatic pal_read(input int a);
    pal_addr = 5'(a);
    tick;
  endtask
  task automatic vblank_edge;
    v_blank = 1'b1;
    tick;
    for (int k = 0; k < 2; k++) begin
      disp[k] = fr[k];
      fr[k] = (fr[k] + 1) % nf[k];
    end
    mx = 0;
    my = 0;
    ovr = 0;
    chk("fdone_u1", fd1, 1);
    chk("fdone_u2", fd2, 1);
    chk("disp_u1", df1, disp[0]);
    chk("disp_u2", df2, disp[1]);
    chk("ovr_clr_u1", ov1, 0);
    chk("ovr_clr_u2", ov2, 0);
    tick;
    chk("fdone_pulse_u1", fd1, 0);
    chk("fdone_pulse_u2", fd2, 0);
    v_blank = 1'b0;
    tick;
  endtask
  task automatic send_pixel(input logic [4:0] idx, input logic grey, input bit busy,
                            input bit wr_same, input bit vb_mid, input bit rst_mid);
    logic [2:0] em;
    int col, lk, ed;
    bit drop;
    int ea[2][4];
    em = 3'($urandom);
    lk = (idx % 4 == 0) ? 0 : int'(idx);
    col = grey ? pal_m[lk] / 16 * 16 : pal_m[lk];
    ed = int'(em) * 64 + col;
    drop = (my == V);
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 4; c++)
        ea[k][c] = fr[k] * H * V * sc[k] * sc[k] + (my * sc[k] + c / 2) * H * sc[k] + mx * sc[k] + c % 2;
    ppu_clock = 1'b1;
    pix_valid = 1'b1;
    pix_index = idx;
    emphasis = em;
    greyscale = grey;
    tick;
    ppu_clock = busy;
    pix_valid = busy;
    emphasis = 3'($urandom);
    if (wr_same) begin
      pal_wr = 1'b1;
      pal_addr = 5'(lk);
      pal_wdata = 6'($urandom);
    end
    chk("wren_n1_u1", fb1.color_wren, 0);
    chk("wren_n1_u2", fb2.color_wren, 0);
    tick;
    ppu_clock = 1'b0;
    pix_valid = 1'b0;
    if (wr_same) begin
      pal_wr = 1'b0;
      pal_m[lk] = int'(pal_wdata);
    end
    if (busy || drop) ovr = 1;
    if (busy) begin
      chk("ovr_busy_u1", ov1, 1);
      chk("ovr_busy_u2", ov2, 1);
    end
    for (int c = 0; c < 4; c++) begin
      chk("wren_u1", fb1.color_wren, (!drop && c == 0) ? 1 : 0);
      if (!drop && c == 0) begin
        chk("addr_u1", fb1.color_addr, ea[0][0]);
        chk("data_u1", fb1.color_data, ed);
      end
      chk("wren_u2", fb2.color_wren, drop ? 0 : 1);
      if (!drop) begin
        chk("addr_u2", fb2.color_addr, ea[1][c]);
        chk("data_u2", fb2.color_data, ed);
      end
      if (vb_mid && c == 1) begin
        chk("fdone_mid_u1", fd1, 1);
        chk("fdone_mid_u2", fd2, 1);
      end
      if (c == 0 && vb_mid) v_blank = 1'b1;
      if (c == 0 && rst_mid) reset = 1'b0;
      tick;
      if (rst_mid) begin
        chk("rst_wren_u1", fb1.color_wren, 0);
        chk("rst_wren_u2", fb2.color_wren, 0);
        chk("rst_ovr_u1", ov1, 0);
        chk("rst_ovr_u2", ov2, 0);
        chk("rst_disp_u2", df2, 0);
        reset = 1'b1;
        mx = 0;
        my = 0;
        fr = '{0, 0};
        disp = '{0, 0};
        ovr = 0;
        return;
      end
    end
    chk("wren_end_u1", fb1.color_wren, 0);
    chk("wren_end_u2", fb2.color_wren, 0);
    v_blank = 1'b0;
    if (!drop) begin
      mx++;
      if (mx == H) begin
        mx = 0;
        my++;
      end
    end
    if (vb_mid) begin
      for (int k = 0; k < 2; k++) begin
        disp[k] = fr[k];
        fr[k] = (fr[k] + 1) % nf[k];
      end
      mx = 0;
      my = 0;
      ovr = 0;
    end
    chk("ovr_u1", ov1, ovr);
    chk("ovr_u2", ov2, ovr);
    chk("dispf_u1", df1, disp[0]);
    chk("dispf_u2", df2, disp[1]);
  endtask
  initial begin
    tick;
    tick;
    chk("rst_wren_u1", fb1.color_wren, 0);
    chk("rst_wren_u2", fb2.color_wren, 0);
    chk("rst_addr_u2", fb2.color_addr, 0);
    chk("rst_data_u2", fb2.color_data, 0);
    chk("rst_disp_u1", df1, 0);
    chk("rst_fdone_u2", fd2, 0);
    chk("rst_ovr_u2", ov2, 0);
    chk("rst_rdata_u1", rd1, 0);
    reset = 1'b1;
    tick;
    for (int a = 0; a < 32; a++) pal_write(a, $urandom_range(0, 63));
    pal_write('h10, 'h2A);
    pal_read('h00);
    chk("pal_mirror_rd", rd1, 'h2A);
    pal_read('h11);
    chk("pal_11_u1", rd1, pal_m[17]);
    for (int a = 0; a < 32; a++) begin
      pal_read(a);
      chk("pal_rd_u1", rd1, pal_m[mir(a)]);
      chk("pal_rd_u2", rd2, pal_m[mir(a)]);
    end
    pal_write('h00, 'h0F);
    pal_write('h05, 'h2A);
    send_pixel(5'h14, 1'b0, 0, 0, 0, 0);
    send_pixel(5'h05, 1'b1, 0, 0, 0, 0);
    for (int i = 2; i < H * V; i++) send_pixel(5'($urandom), 1'($urandom), 0, 0, 0, 0);
    send_pixel(5'($urandom), 1'b0, 0, 0, 0, 0);
    vblank_edge;
    send_pixel(5'($urandom), 1'b0, 0, 0, 0, 0);
    send_pixel(5'($urandom), 1'b0, 0, 1, 0, 0);
    send_pixel(5'($urandom), 1'b1, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) send_pixel(5'($urandom), 1'($urandom), 0, 1'($urandom), 0, 0);
    vblank_edge;
    send_pixel(5'($urandom), 1'b0, 1, 0, 0, 0);
    send_pixel(5'($urandom), 1'b0, 0, 0, 1, 0);
    send_pixel(5'($urandom), 1'b0, 0, 0, 0, 0);
    send_pixel(5'($urandom), 1'b0, 1, 0, 0, 1);
    tick;
    send_pixel(5'($urandom), 1'b0, 0, 0, 0, 0);
    send_pixel(5'($urandom), 1'b1, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
